// File: rtl/ser_shift_seq.sv
// Sequencer for the bit-serial shifter: accepts one command, loads the shifter,
// streams the source until the shift amount is consumed, then opens a WIDTH-cycle result window.
module ser_shift_seq #(
    parameter int WIDTH = 32,
    parameter int CW    = 5
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic          i_req_valid,
    output logic          o_req_ready,
    input  logic [CW-1:0] i_req_shamt,
    input  logic          i_req_right,
    input  logic          i_req_arith,
    input  logic          i_flush,
    input  logic          i_src_msb,
    output logic          o_sh_load,
    output logic [CW-1:0] o_sh_shamt,
    output logic          o_sh_right,
    output logic          o_sh_signbit,
    input  logic          i_sh_done,
    output logic          o_src_en,
    output logic          o_dst_en,
    output logic          o_rsp_valid,
    output logic          o_rsp_err,
    input  logic          i_rsp_ready
);

    typedef enum logic [2:0] {IDLE, INIT, SKIP, RUN, RESP} state_t;

    // Last SKIP cycle before the done-timeout fires (counter then reaches 2*WIDTH-1).
    localparam logic [CW:0]   SKIP_LAST = (CW+1)'(2*WIDTH-2);
    localparam logic [CW-1:0] BIT_LAST  = CW'(WIDTH-1);

    state_t        state;
    logic [CW:0]   skip_cnt;
    logic [CW-1:0] bit_cnt;
    logic          arith_q;

    assign o_req_ready = (state == IDLE);

    // Strobes are registered alongside the state they belong to, so they are
    // valid for exactly the cycles the FSM spends in that state.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state        <= IDLE;
            skip_cnt     <= '0;
            bit_cnt      <= '0;
            arith_q      <= 1'b0;
            o_sh_shamt   <= '0;
            o_sh_right   <= 1'b0;
            o_sh_signbit <= 1'b0;
            o_sh_load    <= 1'b0;
            o_src_en     <= 1'b0;
            o_dst_en     <= 1'b0;
            o_rsp_valid  <= 1'b0;
            o_rsp_err    <= 1'b0;
        end else begin
            o_sh_load <= 1'b0;
            o_src_en  <= 1'b0;
            o_dst_en  <= 1'b0;
            if (i_flush && state != IDLE) begin
                state       <= IDLE;
                o_rsp_valid <= 1'b0;
                o_rsp_err   <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (i_req_valid && !i_flush) begin
                            o_sh_shamt <= i_req_shamt;
                            o_sh_right <= i_req_right;
                            arith_q    <= i_req_arith;
                            o_sh_load  <= 1'b1;
                            state      <= INIT;
                        end
                    end
                    INIT: begin
                        o_sh_signbit <= i_src_msb & arith_q & o_sh_right;
                        skip_cnt     <= '0;
                        o_src_en     <= 1'b1;
                        state        <= SKIP;
                    end
                    SKIP: begin
                        skip_cnt <= skip_cnt + 1'b1;
                        if (i_sh_done) begin
                            bit_cnt  <= '0;
                            o_src_en <= 1'b1;
                            o_dst_en <= 1'b1;
                            state    <= RUN;
                        end else if (skip_cnt == SKIP_LAST) begin
                            o_rsp_valid <= 1'b1;
                            o_rsp_err   <= 1'b1;
                            state       <= RESP;
                        end else begin
                            o_src_en <= 1'b1;
                        end
                    end
                    RUN: begin
                        bit_cnt <= bit_cnt + 1'b1;
                        if (bit_cnt == BIT_LAST) begin
                            o_rsp_valid <= 1'b1;
                            o_rsp_err   <= 1'b0;
                            state       <= RESP;
                        end else begin
                            o_src_en <= 1'b1;
                            o_dst_en <= 1'b1;
                        end
                    end
                    RESP: begin
                        if (i_rsp_ready) begin
                            o_rsp_valid <= 1'b0;
                            o_rsp_err   <= 1'b0;
                            state       <= IDLE;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: doc/ser_shift_seq.md
Name: ser_shift_seq

Overview:
- Sequencer for the bit-serial shifter datapath.
- Accepts one shift command at a time over a valid/ready handshake, pulses the shifter load, and streams the source operand until the shifter reports the shift amount is consumed.
- Then opens a fixed WIDTH-cycle result window for the destination, and returns a completion response.
- Sits between the decode/control logic and the shifter plus serial operand register.

Parameters:
WIDTH, 32, number of result bits streamed per operation; power of two, 8..64
CW, 5, log2(WIDTH); width of the internal bit counter and of the shift amount

Ports:
i_clk  in  1  clock, all state updates on rising edge
i_rst_n  in  1  asynchronous active-low reset
i_req_valid  in  1  command valid
o_req_ready  out  1  command accepted when both high; high only in IDLE
i_req_shamt  in  CW  shift amount
i_req_right  in  1  1 = right shift, 0 = left shift
i_req_arith  in  1  1 = arithmetic (sign-fill) right shift
i_flush  in  1  abort current operation
i_src_msb  in  1  sign bit of source operand, sampled in INIT
o_sh_load  out  1  shifter load strobe
o_sh_shamt  out  CW  registered shift amount to shifter
o_sh_right  out  1  registered direction to shifter
o_sh_signbit  out  1  i_src_msb & arith, registered in INIT
i_sh_done  in  1  shifter count equals shift amount
o_src_en  out  1  advance source serial stream one bit
o_dst_en  out  1  destination captures shifter output this cycle
o_rsp_valid  out  1  operation complete
o_rsp_err  out  1  qualifies o_rsp_valid: done never seen
i_rsp_ready  in  1  response consumed

Behaviour:
- Reset (async, i_rst_n low):
  - state = IDLE, counters = 0.
  - o_sh_shamt / o_sh_right / o_sh_signbit = 0.
  - o_sh_load, o_src_en, o_dst_en, o_rsp_valid, o_rsp_err = 0.
  - o_req_ready = 1 once reset deasserts.
- IDLE:
  - o_req_ready = 1.
  - On i_req_valid & o_req_ready: capture shamt, right, arith into o_sh_* registers; go to INIT.
- INIT (1 cycle):
  - o_sh_load = 1, o_src_en = 0.
  - Register o_sh_signbit = i_src_msb & i_req_arith(captured) & right.
  - Clear skip counter; go to SKIP.
- SKIP:
  - o_src_en = 1; skip counter increments each cycle.
  - If i_sh_done = 1: go to RUN, bit counter = 0. SKIP lasts exactly shamt+1 cycles with a conforming shifter.
  - If the skip counter reaches 2*WIDTH-1 without i_sh_done: go to RESP with o_rsp_err = 1.
- RUN (exactly WIDTH cycles):
  - o_src_en = 1, o_dst_en = 1.
  - Bit counter increments each cycle; at WIDTH-1, go to RESP.
  - Counter wrap-around to 0 does not extend the window.
- RESP:
  - o_rsp_valid = 1 and o_rsp_err held stable until i_rsp_ready.
  - On the handshake, o_rsp_valid and o_rsp_err are cleared next cycle and the state returns to IDLE.
  - i_rsp_ready high while o_rsp_valid is low has no effect.
- i_flush:
  - Highest priority in every non-IDLE state; next state is IDLE.
  - Strobes/enables drop the next cycle; no response is issued; o_rsp_valid is cleared if it was pending.
  - In IDLE, i_flush blocks acceptance that cycle.
- Registered strobes:
  - o_sh_load, o_src_en and o_dst_en are decoded from registered state only, with no combinational path from i_req_*.
  - o_req_ready is decoded from state only.
- Configuration stability: o_sh_shamt and o_sh_right hold their value from acceptance until the next acceptance.
- Latency: acceptance edge to first o_rsp_valid cycle = 1 + (shamt+1) + WIDTH cycles.
- Throughput: at most one operation in flight; back-to-back commands need one IDLE cycle after the response handshake.

Test Plan:
1. Left shift, shamt=0, WIDTH=32 -> o_sh_load 1 cycle; SKIP 1 cycle; o_dst_en high 32 consecutive cycles; o_rsp_valid 34 cycles after accept; o_rsp_err=0.
2. Right arithmetic shift, shamt=5, i_src_msb=1 -> o_sh_signbit=1, o_sh_right=1; o_src_en high 6 cycles before o_dst_en; o_rsp_valid at 39 cycles. Repeat with arith=0 -> o_sh_signbit=0.
3. Shifter model holding i_sh_done=0 -> o_rsp_valid with o_rsp_err=1 after 63 SKIP cycles; o_dst_en never asserted.
4. Response backpressure: i_rsp_ready low for 10 cycles -> o_rsp_valid stays high; o_req_ready stays low; new i_req_valid is not accepted until one cycle after the handshake.
5. i_flush in RUN at bit 12 -> o_dst_en low next cycle; no o_rsp_valid; o_req_ready high next cycle. Repeat flush in SKIP and RESP.
6. i_rst_n pulsed low mid-RUN, asynchronously between edges -> all strobes and o_rsp_valid drop immediately; after release, state is IDLE and a new shamt=31 command completes in 65 cycles.
